fft8_input_reorder: RTL and testbench

Input stage of the 8-point FFT, directly upstream of the first-stage Butterfly_Unit array. It accepts complex FP32 samples one per cycle in natural order and buffers a full 8-sample frame. It then emits the frame as four bit-reversed butterfly pairs, one pair per handshake, ready for radix-2 DIT stage 1. Two frame banks (ping-pong) let frame n+1 be written while frame n is read out.

---
 rtl/fft8_input_reorder.sv | 114 +++++++++++
 tb/tb_fft8_input_reorder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_input_reorder.sv
// fft8_input_reorder
//   Input stage of the 8-point FFT. Collects complex samples in natural order
//   into one of two ping-pong frame banks, then presents each completed frame
//   as four bit-reversed butterfly pairs for radix-2 DIT stage 1.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid / o_ready       sample input handshake
//   i_data_re / i_data_im   sample payload (FP32 bit patterns, passed through)
//   o_valid / i_ready       pair output handshake
//   o_data_0_*              butterfly upper input x[br(2k)]
//   o_data_1_*              butterfly lower input x[br(2k+1)]
//   o_pair_idx              pair index k of the presented pair
//   o_frame_last            presented pair is the last of its frame
module fft8_input_reorder #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data_re,
    input  logic [DATA_W-1:0] i_data_im,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data_0_re,
    output logic [DATA_W-1:0] o_data_0_im,
    output logic [DATA_W-1:0] o_data_1_re,
    output logic [DATA_W-1:0] o_data_1_im,
    output logic [1:0]        o_pair_idx,
    output logic              o_frame_last
);

    logic [1:0][7:0][DATA_W-1:0] mem_re_q, mem_re_d;
    logic [1:0][7:0][DATA_W-1:0] mem_im_q, mem_im_d;
    logic       wr_bank_q, wr_bank_d;
    logic [2:0] wr_cnt_q,  wr_cnt_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] rd_cnt_q,  rd_cnt_d;
    logic [1:0] full_q,    full_d;

    logic       wr_acc, rd_acc;
    logic [2:0] lo_idx, hi_idx;

    // Handshake outputs come straight from state flops only.
    assign o_ready = !full_q[wr_bank_q];
    assign o_valid = full_q[rd_bank_q];

    assign wr_acc = i_valid && o_ready;
    assign rd_acc = o_valid && i_ready;

    // Pair k reads x[br(2k)] and x[br(2k+1)]; with 3-bit reversal that is
    // {0,k0,k1} and {1,k0,k1}.
    assign lo_idx = {1'b0, rd_cnt_q[0], rd_cnt_q[1]};
    assign hi_idx = {1'b1, rd_cnt_q[0], rd_cnt_q[1]};

    assign o_data_0_re  = mem_re_q[rd_bank_q][lo_idx];
    assign o_data_0_im  = mem_im_q[rd_bank_q][lo_idx];
    assign o_data_1_re  = mem_re_q[rd_bank_q][hi_idx];
    assign o_data_1_im  = mem_im_q[rd_bank_q][hi_idx];
    assign o_pair_idx   = rd_cnt_q;
    assign o_frame_last = o_valid && (rd_cnt_q == 2'd3);

    // Write completion and read completion may land on the same edge; they
    // always touch different banks, so both updates to full_d apply.
    always_comb begin
        mem_re_d  = mem_re_q;
        mem_im_d  = mem_im_q;
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        full_d    = full_q;

        if (wr_acc) begin
            mem_re_d[wr_bank_q][wr_cnt_q] = i_data_re;
            mem_im_d[wr_bank_q][wr_cnt_q] = i_data_im;
            wr_cnt_d = wr_cnt_q + 3'd1;
            if (wr_cnt_q == 3'd7) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end

        if (rd_acc) begin
            rd_cnt_d = rd_cnt_q + 2'd1;
            if (rd_cnt_q == 2'd3) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_re_q  <= '0;
            mem_im_q  <= '0;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= 3'd0;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= 2'd0;
            full_q    <= 2'b00;
        end else begin
            mem_re_q  <= mem_re_d;
            mem_im_q  <= mem_im_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            full_q    <= full_d;
        end
    end

endmodule

// File: tb/tb_fft8_input_reorder.sv
// Self-checking bench for fft8_input_reorder: a constant table for the
// single-frame case, then hand sequences and random traffic checked against a
// queue-based model of frames and bit-reversed pairs.
module tb_fft8_input_reorder;

    localparam int W = 32;
    localparam logic [W-1:0] SIGN = 32'h8000_0000;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_data_re, i_data_im;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_data_0_re, o_data_0_im, o_data_1_re, o_data_1_im;
    logic [1:0]   o_pair_idx;
    logic         o_frame_last;

    fft8_input_reorder #(.DATA_W(W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_data_re(i_data_re), .i_data_im(i_data_im),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_data_0_re(o_data_0_re), .o_data_0_im(o_data_0_im),
        .o_data_1_re(o_data_1_re), .o_data_1_im(o_data_1_im),
        .o_pair_idx(o_pair_idx), .o_frame_last(o_frame_last)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [W-1:0] re0, im0, re1, im1;
        logic [1:0]   idx;
    } pair_t;

    pair_t        pq[$];       // pairs not yet accepted downstream, in order
    logic [W-1:0] part_re[$];  // samples of the frame being collected
    logic [W-1:0] part_im[$];
    logic [W-1:0] cur_re, cur_im;
    int           frames_done = 0;

    function automatic logic [2:0] br3(input int i);
        logic [2:0] b;
        b = 3'(i);
        return {b[0], b[1], b[2]};
    endfunction

    task automatic model_reset();
        pq.delete();
        part_re.delete();
        part_im.delete();
    endtask

    task automatic new_sample();
        cur_re = $urandom;
        cur_im = $urandom;
    endtask

    // Frames held = ceil(pairs/4); valid while any held, ready while fewer than 2.
    task automatic check(input string name);
        logic  ev, er, ok;
        pair_t p;
        p  = '{default: '0};
        ev = (pq.size() > 0);
        er = (pq.size() <= 4);
        ok = (o_valid === ev) && (o_ready === er);
        if (ev) begin
            p = pq[0];
            ok = ok && (o_data_0_re === p.re0) && (o_data_0_im === p.im0)
                    && (o_data_1_re === p.re1) && (o_data_1_im === p.im1)
                    && (o_pair_idx === p.idx)
                    && (o_frame_last === (p.idx == 2'd3));
        end else begin
            ok = ok && (o_frame_last === 1'b0);
        end
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s t=%0t got v=%b r=%b k=%0d last=%b d0=%h/%h d1=%h/%h want v=%b r=%b k=%0d d0=%h/%h d1=%h/%h",
                     name, $time, o_valid, o_ready, o_pair_idx, o_frame_last,
                     o_data_0_re, o_data_0_im, o_data_1_re, o_data_1_im,
                     ev, er, p.idx, p.re0, p.im0, p.re1, p.im1);
        end
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic cycle(input logic v, input logic rdy, input string name);
        logic wr, rd;
        i_valid   = v;
        i_ready   = rdy;
        i_data_re = cur_re;
        i_data_im = cur_im;
        check(name);
        wr = v && (pq.size() <= 4);
        rd = rdy && (pq.size() > 0);
        @(posedge i_clk);
        if (rd) void'(pq.pop_front());
        if (wr) begin
            part_re.push_back(cur_re);
            part_im.push_back(cur_im);
            new_sample();
            if (part_re.size() == 8) begin
                for (int k = 0; k < 4; k++) begin
                    pair_t np;
                    np.re0 = part_re[br3(2*k)];
                    np.im0 = part_im[br3(2*k)];
                    np.re1 = part_re[br3(2*k+1)];
                    np.im1 = part_im[br3(2*k+1)];
                    np.idx = 2'(k);
                    pq.push_back(np);
                end
                part_re.delete();
                part_im.delete();
                frames_done++;
            end
        end
        @(negedge i_clk);
    endtask

    task automatic check_reset(input string name);
        n_vec++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data_0_re !== '0 || o_data_0_im !== '0
            || o_data_1_re !== '0 || o_data_1_im !== '0 || o_pair_idx !== 2'd0 || o_frame_last !== 1'b0) begin
            n_bad++;
            $display("FAIL %s got v=%b r=%b k=%0d last=%b d0=%h/%h d1=%h/%h want v=0 r=1 k=0 last=0 data=0",
                     name, o_valid, o_ready, o_pair_idx, o_frame_last,
                     o_data_0_re, o_data_0_im, o_data_1_re, o_data_1_im);
        end
    endtask

    task automatic expect_bit(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    // ---------------- single-frame table ----------------
    typedef struct {
        logic         v;
        logic [W-1:0] re;
        logic         rdy;
        logic         ev, er;
        logic [W-1:0] e0, e1;
        logic [1:0]   eidx;
        logic         elast;
    } vec_t;

    vec_t         tbl[13];
    logic [W-1:0] fv[8];

    initial begin
        logic       dropped;
        int         guard;
        logic [W-1:0] fa0;

        fv = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
               32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, fv[i], 1'b1, 1'b0, 1'b1, '0, '0, 2'd0, 1'b0};
        tbl[8]  = '{1'b0, '0, 1'b1, 1'b1, 1'b1, fv[0], fv[4], 2'd0, 1'b0};
        tbl[9]  = '{1'b0, '0, 1'b1, 1'b1, 1'b1, fv[2], fv[6], 2'd1, 1'b0};
        tbl[10] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, fv[1], fv[5], 2'd2, 1'b0};
        tbl[11] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, fv[3], fv[7], 2'd3, 1'b1};
        tbl[12] = '{1'b0, '0, 1'b1, 1'b0, 1'b1, '0, '0, 2'd0, 1'b0};

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data_re = '0;
        i_data_im = '0;
        new_sample();
        @(negedge i_clk);
        @(negedge i_clk);
        check_reset("reset_state");
        i_rst_n = 1'b1;

        // Single frame from the constant table.
        for (int i = 0; i < 13; i++) begin
            logic ok;
            i_valid   = tbl[i].v;
            i_data_re = tbl[i].re;
            i_data_im = tbl[i].re ^ SIGN;
            i_ready   = tbl[i].rdy;
            ok = (o_valid === tbl[i].ev) && (o_ready === tbl[i].er)
              && (o_pair_idx === tbl[i].eidx) && (o_frame_last === tbl[i].elast);
            if (tbl[i].ev)
                ok = ok && (o_data_0_re === tbl[i].e0) && (o_data_1_re === tbl[i].e1)
                        && (o_data_0_im === (tbl[i].e0 ^ SIGN)) && (o_data_1_im === (tbl[i].e1 ^ SIGN));
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL table[%0d] got v=%b r=%b k=%0d last=%b d0=%h/%h d1=%h/%h want v=%b r=%b k=%0d last=%b d0=%h d1=%h",
                         i, o_valid, o_ready, o_pair_idx, o_frame_last, o_data_0_re, o_data_0_im,
                         o_data_1_re, o_data_1_im, tbl[i].ev, tbl[i].er, tbl[i].eidx, tbl[i].elast,
                         tbl[i].e0, tbl[i].e1);
            end
            @(posedge i_clk);
            @(negedge i_clk);
        end

        // Back-pressure: frame A, then 20 stalled cycles while frame B fills.
        fa0 = cur_re;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, "bp_fill_a");
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, "bp_stall");
        expect_bit("bp_ready_low", o_ready, 1'b0);
        expect_bit("bp_pair0_held", o_data_0_re === fa0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, "bp_drain");

        // Continuous streaming: 4 frames back to back.
        dropped = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (o_ready !== 1'b1) dropped = 1'b1;
            cycle(1'b1, 1'b1, "stream");
        end
        expect_bit("stream_ready_held", dropped, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, "stream_drain");

        // Simultaneous 8th write of frame n+1 and pair-3 accept of frame n.
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, "sim_fill");
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, "sim_overlap");
        expect_bit("sim_valid", o_valid, 1'b1);
        expect_bit("sim_ready", o_ready, 1'b1);
        expect_bit("sim_pair0", o_pair_idx === 2'd0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, "sim_drain");

        // Random gaps on both sides over 50 frames.
        frames_done = 0;
        guard = 0;
        while (frames_done < 50 && guard < 4000) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
            guard++;
        end
        expect_bit("random_frames_done", frames_done >= 50, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, "random_drain");

        // Reset with frame 1 at pair 1 and 5 samples of frame 2 written.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, "rst_fill1");
        cycle(1'b1, 1'b1, "rst_pair0");
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, "rst_fill2");
        i_valid = 1'b0;
        i_ready = 1'b0;
        #2 i_rst_n = 1'b0;
        #1 check_reset("reset_async");
        model_reset();
        @(negedge i_clk);
        check_reset("reset_held");
        i_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, "post_rst_fill");
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, "post_rst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
